// File: rtl/ternary_sampler.sv
// ternary_sampler: turns the free-running 16-bit LFSR coins word into one ternary
// polynomial of N coefficients (byte mod 3, two per word, last one forced to 0).
module ternary_sampler #(
    parameter int unsigned N     = 701,
    parameter int unsigned IDX_W = 10
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [16:1]      i_coins,
    output logic             o_coins_take,
    output logic             o_coeff_valid,
    input  logic             i_coeff_ready,
    output logic [1:0]       o_coeff,
    output logic [IDX_W-1:0] o_coeff_idx,
    output logic             o_busy,
    output logic             o_done
);

    localparam logic [IDX_W-1:0] LP_IDX_PENULT = IDX_W'(N - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_EMIT_LO,
        S_EMIT_HI,
        S_LAST
    } state_t;

    state_t           r_state;
    logic [16:1]      r_hold;
    logic [IDX_W-1:0] r_idx;
    logic             r_coins_take;
    logic             r_valid;
    logic             r_busy;
    logic             r_done;

    logic             w_handshake;
    logic             w_at_penult;
    logic [1:0]       w_coeff;

    // Exact residue of an 8-bit value: 4 == 1 (mod 3), so base-4 digits can be summed.
    function automatic logic [1:0] mod3(input logic [7:0] x);
        logic [3:0] f1;
        logic [2:0] f2;
        logic [2:0] f3;
        f1 = 4'(x[7:6]) + 4'(x[5:4]) + 4'(x[3:2]) + 4'(x[1:0]);
        f2 = 3'(f1[3:2]) + 3'(f1[1:0]);
        f3 = 3'(f2[2]) + 3'(f2[1:0]);
        mod3 = (f3 >= 3'd3) ? 2'(f3 - 3'd3) : f3[1:0];
    endfunction

    assign w_handshake = r_valid & i_coeff_ready;
    assign w_at_penult = (r_idx == LP_IDX_PENULT);

    // Coefficient is decoded from registered state and hold only.
    always_comb begin
        w_coeff = 2'b00;
        case (r_state)
            S_EMIT_LO: w_coeff = mod3(r_hold[8:1]);
            S_EMIT_HI: w_coeff = mod3(r_hold[16:9]);
            default:   w_coeff = 2'b00;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_hold       <= '0;
            r_idx        <= '0;
            r_coins_take <= 1'b0;
            r_valid      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state      <= S_LOAD;
                        r_idx        <= '0;
                        r_coins_take <= 1'b1;
                        r_busy       <= 1'b1;
                    end
                end
                S_LOAD: begin
                    r_hold       <= i_coins;
                    r_state      <= S_EMIT_LO;
                    r_coins_take <= 1'b0;
                    r_valid      <= 1'b1;
                end
                S_EMIT_LO: begin
                    if (w_handshake) begin
                        r_idx   <= r_idx + IDX_W'(1);
                        r_state <= w_at_penult ? S_LAST : S_EMIT_HI;
                    end
                end
                S_EMIT_HI: begin
                    if (w_handshake) begin
                        r_idx <= r_idx + IDX_W'(1);
                        if (w_at_penult) begin
                            r_state <= S_LAST;
                        end else begin
                            r_state      <= S_LOAD;
                            r_valid      <= 1'b0;
                            r_coins_take <= 1'b1;
                        end
                    end
                end
                S_LAST: begin
                    if (w_handshake) begin
                        r_state <= S_IDLE;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_valid      <= 1'b0;
                    r_busy       <= 1'b0;
                    r_coins_take <= 1'b0;
                end
            endcase
        end
    end

    assign o_coins_take  = r_coins_take;
    assign o_coeff_valid = r_valid;
    assign o_coeff       = w_coeff;
    assign o_coeff_idx   = r_idx;
    assign o_busy        = r_busy;
    assign o_done        = r_done;

endmodule

// File: tb/tb_ternary_sampler.sv
// Bench for ternary_sampler: per-scenario tasks against a byte-mod-3 reference model
// built from the captured coins words.
`timescale 1ns/1ps
module tb_ternary_sampler;

    localparam int unsigned N_A   = 701;
    localparam int unsigned IDX_A = 10;
    localparam int unsigned N_B   = 4;
    localparam int unsigned IDX_B = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             start_a, start_b, ready_a, ready_b;
    logic [15:0]      coins;
    logic             take_a, valid_a, busy_a, done_a;
    logic [1:0]       coeff_a;
    logic [IDX_A-1:0] idx_a;
    logic             take_b, valid_b, busy_b, done_b;
    logic [1:0]       coeff_b;
    logic [IDX_B-1:0] idx_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ternary_sampler #(.N(N_A), .IDX_W(IDX_A)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_start(start_a), .i_coins(coins),
        .o_coins_take(take_a), .o_coeff_valid(valid_a), .i_coeff_ready(ready_a),
        .o_coeff(coeff_a), .o_coeff_idx(idx_a), .o_busy(busy_a), .o_done(done_a)
    );

    ternary_sampler #(.N(N_B), .IDX_W(IDX_B)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_start(start_b), .i_coins(coins),
        .o_coins_take(take_b), .o_coeff_valid(valid_b), .i_coeff_ready(ready_b),
        .o_coeff(coeff_b), .o_coeff_idx(idx_b), .o_busy(busy_b), .o_done(done_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected coefficient i of a word: even index -> low byte, odd -> high byte, value mod 3.
    function automatic logic [1:0] ref_coeff(input logic [15:0] w, input int i);
        int b;
        b = (i % 2 == 1) ? int'(w[15:8]) : int'(w[7:0]);
        return 2'(b % 3);
    endfunction

    // Runs one N_A polynomial; checks index order, coefficient values and stall stability.
    task automatic run_a(input int coin_mode, input bit rand_ready, input int poke_at,
                         output int n_xfer, output int n_take, output int done_t, output int n_poke);
        logic [15:0]      words[$];
        logic [1:0]       exp_c;
        logic [1:0]       prev_c;
        logic [IDX_A-1:0] prev_i;
        bit               stalled;
        bit               fin;
        int               stall_left;
        int               t;
        n_xfer = 0; n_take = 0; done_t = -1; n_poke = 0;
        stalled = 1'b0; fin = 1'b0; stall_left = 0; prev_c = '0; prev_i = '0;
        ready_a = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        t = 0;
        while (!fin && t < 6000) begin
            if (stalled) begin
                n_cmp++;
                if (coeff_a !== prev_c || idx_a !== prev_i) begin
                    n_err++;
                    $display("FAIL stall_stable t=%0d: got coeff=%b idx=%0d, need coeff=%b idx=%0d",
                             t, coeff_a, idx_a, prev_c, prev_i);
                end
            end
            if (done_a === 1'b1) begin
                fin = 1'b1;
                done_t = t;
            end else begin
                if (rand_ready) begin
                    if (stall_left > 0) begin
                        ready_a = 1'b0;
                        stall_left--;
                    end else if ($urandom_range(0, 49) == 0) begin
                        ready_a = 1'b0;
                        stall_left = 19;
                    end else begin
                        ready_a = ($urandom_range(0, 2) != 0);
                    end
                end else begin
                    ready_a = 1'b1;
                end
                case (coin_mode)
                    0:       coins = 16'h0201;
                    1:       coins = {8'(2 * n_take + 1), 8'(2 * n_take)};
                    default: coins = 16'($urandom);
                endcase
                if (take_a === 1'b1) begin
                    words.push_back(coins);
                    n_take++;
                end
                if (valid_a === 1'b1 && ready_a) begin
                    n_cmp++;
                    if (idx_a !== IDX_A'(n_xfer)) begin
                        n_err++;
                        $display("FAIL idx_order: got %0d, need %0d", idx_a, n_xfer);
                    end
                    n_cmp++;
                    if (n_xfer != N_A - 1 && words.size() <= n_xfer / 2) begin
                        n_err++;
                        $display("FAIL coins_word: coeff %0d emitted with only %0d words taken",
                                 n_xfer, words.size());
                    end else begin
                        exp_c = (n_xfer == N_A - 1) ? 2'b00 : ref_coeff(words[n_xfer / 2], n_xfer);
                        if (coeff_a !== exp_c) begin
                            n_err++;
                            $display("FAIL coeff_value idx=%0d: got %b, need %b", n_xfer, coeff_a, exp_c);
                        end
                    end
                    n_xfer++;
                end
                start_a = (poke_at >= 0 && n_xfer == poke_at && n_poke == 0);
                if (start_a) n_poke++;
                stalled = (valid_a === 1'b1) && !ready_a;
                prev_c = coeff_a;
                prev_i = idx_a;
                tick();
                start_a = 1'b0;
                t++;
            end
        end
        if (!fin) begin
            n_cmp++;
            n_err++;
            $display("FAIL run_timeout: got no done in %0d cycles, need done", t);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; ready_a = 1'b0; ready_b = 1'b0; coins = '0;
        tick();
        tick();
        n_cmp++;
        if ({take_a, valid_a, busy_a, done_a, coeff_a} !== 6'b0 || idx_a !== '0) begin
            n_err++;
            $display("FAIL reset_a: got take=%b valid=%b busy=%b done=%b coeff=%b idx=%0d, need all 0",
                     take_a, valid_a, busy_a, done_a, coeff_a, idx_a);
        end
        n_cmp++;
        if ({take_b, valid_b, busy_b, done_b, coeff_b} !== 6'b0 || idx_b !== '0) begin
            n_err++;
            $display("FAIL reset_b: got take=%b valid=%b busy=%b done=%b, need all 0",
                     take_b, valid_b, busy_b, done_b);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_fixed_word();
        int nx, nt, dt, np;
        run_a(0, 1'b0, -1, nx, nt, dt, np);
        n_cmp++;
        if (nx != N_A) begin n_err++; $display("FAIL fixed_count: got %0d, need %0d", nx, N_A); end
        n_cmp++;
        if (dt != 1051) begin n_err++; $display("FAIL fixed_done_time: got %0d, need 1051", dt); end
        n_cmp++;
        if (nt != 350) begin n_err++; $display("FAIL fixed_takes: got %0d, need 350", nt); end
        n_cmp++;
        if (busy_a !== 1'b0) begin n_err++; $display("FAIL fixed_busy_at_done: got %b, need 0", busy_a); end
        tick();
        n_cmp++;
        if (done_a !== 1'b0) begin n_err++; $display("FAIL fixed_done_pulse: got %b, need 0", done_a); end
    endtask

    task automatic test_mod3_sweep();
        int nx, nt, dt, np;
        run_a(1, 1'b0, -1, nx, nt, dt, np);
        n_cmp++;
        if (nx != N_A || nt != 350) begin
            n_err++;
            $display("FAIL sweep_counts: got xfer=%0d take=%0d, need %0d and 350", nx, nt, N_A);
        end
    endtask

    task automatic test_backpressure();
        int nx, nt, dt, np;
        run_a(2, 1'b1, -1, nx, nt, dt, np);
        n_cmp++;
        if (nx != N_A || nt != 350) begin
            n_err++;
            $display("FAIL bp_counts: got xfer=%0d take=%0d, need %0d and 350", nx, nt, N_A);
        end
        n_cmp++;
        if (dt < 1051) begin n_err++; $display("FAIL bp_done_time: got %0d, need >= 1051", dt); end
    endtask

    task automatic test_start_while_busy();
        int nx, nt, dt, np;
        run_a(2, 1'b0, 300, nx, nt, dt, np);
        n_cmp++;
        if (np != 1 || nx != N_A || dt != 1051) begin
            n_err++;
            $display("FAIL busy_start_run: got poke=%0d xfer=%0d done_t=%0d, need 1, %0d, 1051", np, nx, dt, N_A);
        end
        // A start in the done cycle must be accepted.
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        n_cmp++;
        if (take_a !== 1'b1 || busy_a !== 1'b1 || done_a !== 1'b0) begin
            n_err++;
            $display("FAIL start_on_done: got take=%b busy=%b done=%b, need 1 1 0", take_a, busy_a, done_a);
        end
    endtask

    task automatic test_reset_mid();
        int t;
        t = 0;
        ready_a = 1'b1;
        while (!(valid_a === 1'b1 && idx_a == IDX_A'(123)) && t < 3000) begin
            coins = 16'($urandom);
            tick();
            t++;
        end
        n_cmp++;
        if (t >= 3000) begin n_err++; $display("FAIL reach_idx123: got timeout, need idx 123"); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if (busy_a !== 1'b0 || valid_a !== 1'b0 || done_a !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid: got busy=%b valid=%b done=%b, need 0 0 0", busy_a, valid_a, done_a);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if (done_a !== 1'b0 || busy_a !== 1'b0) begin
                n_err++;
                $display("FAIL reset_quiet: got done=%b busy=%b, need 0 0", done_a, busy_a);
            end
        end
        coins = 16'h0201;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        tick();
        n_cmp++;
        if (valid_a !== 1'b1 || idx_a !== '0 || coeff_a !== ref_coeff(16'h0201, 0)) begin
            n_err++;
            $display("FAIL restart: got valid=%b idx=%0d coeff=%b, need 1 0 %b",
                     valid_a, idx_a, coeff_a, ref_coeff(16'h0201, 0));
        end
    endtask

    task automatic test_odd_n();
        logic [1:0] exp_b [N_B];
        int nx, nt, dt, t;
        exp_b = '{2'b01, 2'b10, 2'b01, 2'b00};
        nx = 0; nt = 0; dt = -1; t = 0;
        coins = 16'h0201;
        ready_b = 1'b1;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        while (dt < 0 && t < 50) begin
            if (done_b === 1'b1) begin
                dt = t;
            end else begin
                if (take_b === 1'b1) nt++;
                if (valid_b === 1'b1) begin
                    n_cmp++;
                    if (nx >= int'(N_B) || idx_b !== IDX_B'(nx) || coeff_b !== exp_b[nx % N_B]) begin
                        n_err++;
                        $display("FAIL odd_coeff #%0d: got idx=%0d coeff=%b, need idx=%0d coeff=%b",
                                 nx, idx_b, coeff_b, nx, exp_b[nx % N_B]);
                    end
                    nx++;
                end
                tick();
                t++;
            end
        end
        n_cmp++;
        if (nx != int'(N_B) || nt != 2 || dt != 6) begin
            n_err++;
            $display("FAIL odd_summary: got xfer=%0d take=%0d done_t=%0d, need 4 2 6", nx, nt, dt);
        end
    endtask

    initial begin
        test_reset();
        test_fixed_word();
        test_mod3_sweep();
        test_backpressure();
        test_start_while_busy();
        test_reset_mid();
        test_odd_n();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
